// File: rtl/tdc_uart_rx_if.sv
// Bundles the UART receive pin and the byte/status outputs of tdc_uart_rx.
// The receiver uses the master modport; the consumer uses slave.
interface tdc_uart_rx_if;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   modport master (
      input  rx,
      output data, valid, frame_err, parity_err, busy
   );

   modport slave (
      output rx,
      input  data, valid, frame_err, parity_err, busy
   );
endinterface

// File: rtl/tdc_uart_rx.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined) for TDC host commands.
// Samples each bit at mid-bit; returns to IDLE at mid-stop so back-to-back frames are not missed.
module tdc_uart_rx #(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic          clk,
   input  logic          reset,
   tdc_uart_rx_if.master rx_if
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif

   logic             sync1_q, sync2_q;
   logic             rxs;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       sr_q, sr_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             frame_err_q, frame_err_d;
   logic             par_good;
`ifdef UART_RX_PARITY_EN
   logic             par_ok_q, par_ok_d;
   logic             parity_err_q, parity_err_d;
`endif

   // Two-flop synchroniser, idle-high on reset so no spurious start is seen
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx_if.rx;
         sync2_q <= sync1_q;
      end
   end

   assign rxs = sync2_q;

`ifdef UART_RX_PARITY_EN
   assign par_good = par_ok_q;
`else
   assign par_good = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      bit_d       = bit_q;
      sr_d        = sr_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_d     = par_ok_q;
      parity_err_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            bit_d = 3'd0;
            if (!rxs) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               state_d = rxs ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               sr_d  = {rxs, sr_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == FULL_M1) begin
               cnt_d    = '0;
               par_ok_d = (rxs == ^sr_q);
               state_d  = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               if (rxs) begin
                  state_d = S_IDLE;
                  if (par_good) begin
                     data_d  = sr_q;
                     valid_d = 1'b1;
                  end else begin
`ifdef UART_RX_PARITY_EN
                     parity_err_d = 1'b1;
`endif
                  end
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            // Held-low line: wait for the line to recover before hunting for a start bit
            cnt_d = '0;
            if (rxs) state_d = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_q       <= 3'd0;
         sr_q        <= 8'h00;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         sr_q        <= sr_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         par_ok_q     <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_ok_q     <= par_ok_d;
         parity_err_q <= parity_err_d;
      end
   end
   assign rx_if.parity_err = parity_err_q;
`else
   assign rx_if.parity_err = 1'b0;
`endif

   assign rx_if.data      = data_q;
   assign rx_if.valid     = valid_q;
   assign rx_if.frame_err = frame_err_q;
   assign rx_if.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_tdc_uart_rx.sv
// Directed bench for tdc_uart_rx at 8 clocks per bit; define UART_RX_PARITY_EN to cover the 8E1 build.
module tb_tdc_uart_rx;
   localparam int N = 8;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
   localparam int T_PULSE = 86;  // 2 + 4 + 9*8 + 8
`else
   localparam bit PAR_EN = 1'b0;
   localparam int T_PULSE = 78;  // 2 + 4 + 9*8
`endif

   logic clk = 1'b0;
   logic reset;
   tdc_uart_rx_if u_if ();

   tdc_uart_rx #(.CLKS_PER_BIT(N)) dut (
      .clk   (clk),
      .reset (reset),
      .rx_if (u_if.master)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;
   int n_valid, n_ferr, n_perr, n_busy, n_overlap;
   int last_valid_cyc;
   logic busy_at_valid;
   logic [7:0] vq[$];
   int t0_last;

   always @(negedge clk) begin
      if (!reset) begin
         if (u_if.valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            busy_at_valid  = u_if.busy;
            vq.push_back(u_if.data);
         end
         if (u_if.frame_err) n_ferr++;
         if (u_if.parity_err) n_perr++;
         if (u_if.busy) n_busy++;
         if (int'(u_if.valid) + int'(u_if.frame_err) + int'(u_if.parity_err) > 1) n_overlap++;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("check %s: got %0h ok", tag, got);
      end
   endtask

   task automatic clear_mon();
      n_valid = 0; n_ferr = 0; n_perr = 0; n_busy = 0;
      last_valid_cyc = -1;
      busy_at_valid  = 1'bx;
      vq.delete();
   endtask

   // Caller is always positioned 1 time unit after a rising edge
   task automatic drive_bit(input logic v);
      u_if.rx = v;
      repeat (N) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cycles);
      u_if.rx = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop);
      t0_last = cyc + 1;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (PAR_EN) drive_bit((^d) ^ par_bad);
      drive_bit(stop);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      u_if.rx = 1'b1;
      clear_mon();
      n_overlap = 0;
      repeat (3) @(negedge clk);
      check_val("rst_data",  u_if.data, 32'h00);
      check_val("rst_valid", u_if.valid, 0);
      check_val("rst_ferr",  u_if.frame_err, 0);
      check_val("rst_perr",  u_if.parity_err, 0);
      check_val("rst_busy",  u_if.busy, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle(50);
      check_val("idle_pulses", n_valid + n_ferr + n_perr, 0);
      check_val("idle_busy",   n_busy, 0);

      // Single byte with latency check
      clear_mon();
      send_frame(8'hA5, 1'b0, 1'b1);
      idle(10);
      check_val("single_nvalid", n_valid, 1);
      check_val("single_data",   u_if.data, 32'hA5);
      check_val("single_time",   last_valid_cyc, t0_last + T_PULSE);
      check_val("single_busy",   busy_at_valid, 0);

      // Back-to-back, no idle gap
      clear_mon();
      send_frame(8'h00, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      send_frame(8'h3C, 1'b0, 1'b1);
      idle(10);
      check_val("b2b_nvalid", n_valid, 3);
      if (vq.size() == 3) begin
         check_val("b2b_d0", vq[0], 32'h00);
         check_val("b2b_d1", vq[1], 32'hFF);
         check_val("b2b_d2", vq[2], 32'h3C);
      end
      check_val("b2b_errs", n_ferr + n_perr, 0);

      // Short glitch is a false start
      clear_mon();
      u_if.rx = 1'b0;
      repeat (3) @(posedge clk); #1;
      idle(20);
      check_val("glitch_pulses", n_valid + n_ferr + n_perr, 0);
      check_val("glitch_busy",   u_if.busy, 0);

      // Stop bit low, then line held low for 30 bits
      clear_mon();
      send_frame(8'h42, 1'b0, 1'b0);
      u_if.rx = 1'b0;
      repeat (30 * N) @(posedge clk); #1;
      check_val("brk_nferr",  n_ferr, 1);
      check_val("brk_nvalid", n_valid + n_perr, 0);
      check_val("brk_data",   u_if.data, 32'h3C);
      check_val("brk_busy",   u_if.busy, 1);
      idle(20);
      check_val("brk_rel_busy", u_if.busy, 0);
      check_val("brk_rel_pulses", n_valid + n_ferr + n_perr, 1);
      send_frame(8'h5B, 1'b0, 1'b1);
      idle(10);
      check_val("brk_new_nvalid", n_valid, 1);
      check_val("brk_new_data",   u_if.data, 32'h5B);

`ifdef UART_RX_PARITY_EN
      clear_mon();
      send_frame(8'h07, 1'b1, 1'b1);
      idle(10);
      check_val("par_bad_nperr",  n_perr, 1);
      check_val("par_bad_nvalid", n_valid, 0);
      check_val("par_bad_data",   u_if.data, 32'h5B);
      clear_mon();
      send_frame(8'h07, 1'b0, 1'b1);
      idle(10);
      check_val("par_ok_nvalid", n_valid, 1);
      check_val("par_ok_data",   u_if.data, 32'h07);
      check_val("par_ok_nperr",  n_perr, 0);
`endif

      // Reset in the middle of D4 of 0x5A, then a clean 0x81
      clear_mon();
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'(8'h5A >> i));
      u_if.rx = 1'b0;
      repeat (N / 2) @(posedge clk); #1;
      reset   = 1'b1;
      u_if.rx = 1'b1;
      repeat (3) @(posedge clk); #1;
      check_val("midrst_data", u_if.data, 32'h00);
      reset = 1'b0;
      idle(20);
      send_frame(8'h81, 1'b0, 1'b1);
      idle(10);
      check_val("midrst_nvalid", n_valid, 1);
      check_val("midrst_data81", u_if.data, 32'h81);
      check_val("midrst_errs",   n_ferr + n_perr, 0);
      check_val("overlap",       n_overlap, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
